alu_issue_stage: RTL and testbench

//  Producer side of the ALU interface. Decodes an RV32I instruction (funct3/funct7/opcode),

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_issue_stage_if.sv | 31 +++
 rtl/alu_decode.sv | 89 ++++++++
 rtl/alu_issue_stage.sv | 96 +++++++++
 tb/tb_alu_issue_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALU operation codes, result selects,
// RV32I opcodes and the decoded-entry record carried through the stage.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_XOR = 3'b011,
    ALU_AND = 3'b100,
    ALU_SRA = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_SLT  = 2'b01,
    RES_SLTU = 2'b10,
    RES_BR   = 2'b11
  } res_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } occ_e;

  typedef struct packed {
    alu_op_e          alu_op;
    logic [XLEN-1:0]  data_a;
    logic [XLEN-1:0]  data_b;
    res_sel_e         res_sel;
    logic [4:0]       rd;
    logic             illegal;
  } issue_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream (instruction + operands) and downstream (ALU operands) handshakes of the issue stage.
interface alu_issue_stage_if
  import alu_pkg::*;
  ();

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  alu_op_e         alu_op;
  logic [XLEN-1:0] dataA;
  logic [XLEN-1:0] dataB;
  res_sel_e        res_sel;
  logic [4:0]      rd;
  logic            illegal;

  modport master (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_op, dataA, dataB, res_sel, rd, illegal
  );

  modport slave (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_op, dataA, dataB, res_sel, rd, illegal
  );

endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I decode: picks the ALU operation, operands, result select and rd,
// or flags the instruction illegal with all other fields zeroed.
module alu_decode
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_t          dec
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;
  logic            is_op, alt, check_f7, legal, shift;
  alu_op_e         op;
  res_sel_e        res;
  logic [XLEN-1:0] op_a, op_b;
  logic [4:0]      rd_sel;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign is_op  = (opcode == OPC_OP);
  assign alt    = (funct7 == F7_ALT);
  // OP-IMM non-shift instructions carry immediate bits in funct7, so only shifts are checked there
  assign check_f7 = is_op || (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    legal  = 1'b1;
    shift  = 1'b0;
    op     = ALU_ADD;
    res    = RES_ALU;
    op_a   = '0;
    op_b   = '0;
    rd_sel = instr[11:7];
    dec    = '0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        op_a = rs1_data;
        op_b = is_op ? rs2_data : imm_i;
        if (check_f7 && (funct7 != F7_BASE) && !alt)
          legal = 1'b0;
        if (check_f7 && alt && !((funct3 == 3'b101) || (funct3 == 3'b000 && is_op)))
          legal = 1'b0;
        case (funct3)
          3'b000: op = (is_op && alt) ? ALU_SUB : ALU_ADD;
          3'b001: begin op = ALU_SLL; shift = 1'b1; end
          3'b010: begin op = ALU_SUB; res = RES_SLT;  end
          3'b011: begin op = ALU_SUB; res = RES_SLTU; end
          3'b100: op = ALU_XOR;
          3'b101: begin op = alt ? ALU_SRA : ALU_SRL; shift = 1'b1; end
          3'b110: op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      OPC_LUI:   begin op_a = '0;       op_b = imm_u; end
      OPC_AUIPC: begin op_a = pc;       op_b = imm_u; end
      OPC_LOAD:  begin op_a = rs1_data; op_b = imm_i; end
      OPC_STORE: begin op_a = rs1_data; op_b = imm_s; rd_sel = 5'd0; end
      OPC_BRANCH: begin
        op     = ALU_SUB;
        op_a   = rs1_data;
        op_b   = rs2_data;
        res    = RES_BR;
        rd_sel = 5'd0;
      end
      default: legal = 1'b0;
    endcase
    // The ALU shifter uses all of dataB, so the shift amount is trimmed here
    if (shift)
      op_b = {27'b0, op_b[4:0]};
    if (legal) begin
      dec.alu_op  = op;
      dec.data_a  = op_a;
      dec.data_b  = op_b;
      dec.res_sel = res;
      dec.rd      = rd_sel;
    end else begin
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX register for the ALU: decode, then a two-entry skid (or single register) with
// valid/ready on both sides and a flush that empties the stage.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int SKID = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  alu_issue_stage_if.master   bus
);

  occ_e   state_reg, state_next;
  issue_t main_reg, skid_reg, dec;
  logic   in_xfer, out_xfer;
  logic   load_main, load_skid, move_skid;

  alu_decode u_decode (
    .instr    (bus.instr),
    .pc       (bus.pc),
    .rs1_data (bus.rs1_data),
    .rs2_data (bus.rs2_data),
    .dec      (dec)
  );

  generate
    if (SKID != 0) begin : g_skid
      assign bus.in_ready = (state_reg != ST_FULL);
    end else begin : g_single
      assign bus.in_ready = (state_reg == ST_EMPTY) | bus.out_ready;
    end
  endgenerate

  assign bus.out_valid = (state_reg != ST_EMPTY);
  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign out_xfer      = bus.out_valid & bus.out_ready;

  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state_reg)
      ST_EMPTY: if (in_xfer) begin
        state_next = ST_ONE;
        load_main  = 1'b1;
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_next = ST_FULL;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: if (out_xfer) begin
        state_next = ST_ONE;
        move_skid  = 1'b1;
      end
      default: state_next = ST_EMPTY;
    endcase
    if (flush) begin
      state_next = ST_EMPTY;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      move_skid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load_main)
        main_reg <= dec;
      else if (move_skid)
        main_reg <= skid_reg;
      if (load_skid)
        skid_reg <= dec;
    end
  end

  assign bus.alu_op  = main_reg.alu_op;
  assign bus.dataA   = main_reg.data_a;
  assign bus.dataB   = main_reg.data_b;
  assign bus.res_sel = main_reg.res_sel;
  assign bus.rd      = main_reg.rd;
  assign bus.illegal = main_reg.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions with hand-decoded expectations,
// backpressure, flush and reset checks.
module tb_alu_issue_stage;
  import alu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] instr, pc, rs1, rs2;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vt[18];
  vec_t exp_q[$];

  alu_issue_stage_if bus ();

  alu_issue_stage #(.SKID(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic [31:0] instr, pc, rs1, rs2,
                              input logic [2:0] op, input logic [31:0] a, b,
                              input logic [1:0] rs, input logic [4:0] rd, input logic ill);
    vec_t v;
    v.name = nm; v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.op = op; v.a = a; v.b = b; v.rs = rs; v.rd = rd; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else
      $display("check %s = %h ok", nm, act);
  endtask

  task automatic drive(input int idx);
    bus.instr    = vt[idx].instr;
    bus.pc       = vt[idx].pc;
    bus.rs1_data = vt[idx].rs1;
    bus.rs2_data = vt[idx].rs2;
    bus.in_valid = 1'b1;
  endtask

  // Holds the instruction until accepted; the expectation is queued at the accepting edge
  task automatic send(input int idx);
    bit done = 0;
    drive(idx);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (!flush) exp_q.push_back(vt[idx]);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout %s: in_ready stayed 0, required 1", vt[idx].name);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got op=%0d A=%h B=%h rd=%0d, required no output",
                 bus.alu_op, bus.dataA, bus.dataB, bus.rd);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        $display("txn %s: op=%0d A=%h B=%h res=%0d rd=%0d ill=%0d",
                 e.name, bus.alu_op, bus.dataA, bus.dataB, bus.res_sel, bus.rd, bus.illegal);
        if (3'(bus.alu_op) !== e.op || bus.dataA !== e.a || bus.dataB !== e.b ||
            2'(bus.res_sel) !== e.rs || bus.rd !== e.rd || bus.illegal !== e.ill) begin
          n_bad++;
          $display("FAIL %s: got op=%0d A=%h B=%h res=%0d rd=%0d ill=%0d required op=%0d A=%h B=%h res=%0d rd=%0d ill=%0d",
                   e.name, bus.alu_op, bus.dataA, bus.dataB, bus.res_sel, bus.rd, bus.illegal,
                   e.op, e.a, e.b, e.rs, e.rd, e.ill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk("sub",      32'h402081B3, 0, 5, 7, 3'd1, 5, 7, 2'd0, 5'd3, 0);
    vt[1]  = mk("srai",     32'h4050D213, 0, 32'h80000000, 0, 3'd5, 32'h80000000, 5, 2'd0, 5'd4, 0);
    vt[2]  = mk("sll",      32'h002092B3, 0, 1, 32'h23, 3'd7, 1, 3, 2'd0, 5'd5, 0);
    vt[3]  = mk("ill_7f",   32'h0000007F, 0, 32'h11, 32'h22, 3'd0, 0, 0, 2'd0, 5'd0, 1);
    vt[4]  = mk("lui",      32'h12345337, 0, 32'h99, 0, 3'd0, 0, 32'h12345000, 2'd0, 5'd6, 0);
    vt[5]  = mk("slt",      32'h0020A3B3, 0, 3, 9, 3'd1, 3, 9, 2'd1, 5'd7, 0);
    vt[6]  = mk("beq",      32'h00208463, 0, 32'hAA, 32'hBB, 3'd1, 32'hAA, 32'hBB, 2'd3, 5'd0, 0);
    vt[7]  = mk("auipc",    32'hFFFFF097, 32'h1000, 0, 0, 3'd0, 32'h1000, 32'hFFFFF000, 2'd0, 5'd1, 0);
    vt[8]  = mk("sw",       32'hFE20AE23, 0, 32'h100, 5, 3'd0, 32'h100, 32'hFFFFFFFC, 2'd0, 5'd0, 0);
    vt[9]  = mk("ill_mul",  32'h022081B3, 0, 1, 2, 3'd0, 0, 0, 2'd0, 5'd0, 1);
    vt[10] = mk("ill_alt",  32'h402091B3, 0, 1, 2, 3'd0, 0, 0, 2'd0, 5'd0, 1);
    vt[11] = mk("lw",       32'h8000A503, 0, 32'h2000, 0, 3'd0, 32'h2000, 32'hFFFFF800, 2'd0, 5'd10, 0);
    vt[12] = mk("ill_lo",   32'h402081B0, 0, 1, 2, 3'd0, 0, 0, 2'd0, 5'd0, 1);
    vt[13] = mk("sltu",     32'h0020B3B3, 0, 4, 8, 3'd1, 4, 8, 2'd2, 5'd7, 0);
    vt[14] = mk("andi",     32'hFF00F413, 0, 1, 0, 3'd4, 1, 32'hFFFFFFF0, 2'd0, 5'd8, 0);
    vt[15] = mk("srl",      32'h0020D4B3, 0, 32'hF0, 32'hFFFFFFE4, 3'd6, 32'hF0, 4, 2'd0, 5'd9, 0);
    vt[16] = mk("xor",      32'h0020C5B3, 0, 32'h0F, 32'h3C, 3'd3, 32'h0F, 32'h3C, 2'd0, 5'd11, 0);
    vt[17] = mk("or",       32'h0020E633, 0, 32'h10, 32'h01, 3'd2, 32'h10, 32'h01, 2'd0, 5'd12, 0);

    bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.out_ready = 1'b0;

    // reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_alu_op",    bus.alu_op, 0);
    chk("rst_dataA",     bus.dataA, 0);
    chk("rst_dataB",     bus.dataB, 0);
    chk("rst_res_sel",   bus.res_sel, 0);
    chk("rst_rd",        bus.rd, 0);
    chk("rst_illegal",   bus.illegal, 0);
    @(posedge clk); #1;

    // streaming, latency of one cycle
    bus.out_ready = 1'b1;
    send(0);
    @(negedge clk);
    chk("latency_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    for (int i = 1; i < 14; i++) send(i);
    drain();

    // backpressure: two accepted, third held off until release
    bus.out_ready = 1'b0;
    send(14);
    send(15);
    drive(16);
    @(negedge clk);
    chk("bp_in_ready_full", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(16);
    drain();

    // flush while full with a simultaneous input
    bus.out_ready = 1'b0;
    send(17);
    send(5);
    drive(6);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // normal operation resumes after flush
    send(2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
